// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: widths, idle opmode and payload types shared by the dsp
// command sequencer. Tag storage is compiled in with DSP_SEQ_TAG_EN.
package dsp_seq_pkg;

    localparam int OPMODE_W = 8;
    localparam int AB_W     = 18;
    localparam int C_W      = 48;
    localparam int P_W      = 48;
    localparam int TAG_W    = 4;

    // Z=P, X=0, add: the slice keeps P unchanged while idle.
    localparam logic [OPMODE_W-1:0] OPMODE_NOP = 8'h08;

    typedef struct packed {
        logic [OPMODE_W-1:0] opmode;
        logic [AB_W-1:0]     a;
        logic [AB_W-1:0]     b;
        logic [AB_W-1:0]     d;
        logic [C_W-1:0]      c;
        logic                carryin;
    } dsp_cmd_t;

    typedef struct packed {
        logic [P_W-1:0]   p;
        logic             carryout;
`ifdef DSP_SEQ_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
    } dsp_res_t;

    localparam dsp_cmd_t DSP_CMD_NOP = '{opmode: OPMODE_NOP, default: '0};

endpackage

// File: rtl/dsp_seq_if.sv
// dsp_seq_if: command and result valid/ready channels of the sequencer.
// cmd_tag/res_tag exist only with DSP_SEQ_TAG_EN.
interface dsp_seq_if;
    import dsp_seq_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OPMODE_W-1:0] cmd_opmode;
    logic [AB_W-1:0]     cmd_a;
    logic [AB_W-1:0]     cmd_b;
    logic [AB_W-1:0]     cmd_d;
    logic [C_W-1:0]      cmd_c;
    logic                cmd_carryin;
    logic                res_valid;
    logic                res_ready;
    logic [P_W-1:0]      res_p;
    logic                res_carryout;
`ifdef DSP_SEQ_TAG_EN
    logic [TAG_W-1:0]    cmd_tag;
    logic [TAG_W-1:0]    res_tag;
`endif

    modport master (
        output cmd_valid, cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin,
`ifdef DSP_SEQ_TAG_EN
        output cmd_tag,
        input  res_tag,
`endif
        input  cmd_ready, res_valid, res_p, res_carryout,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin,
`ifdef DSP_SEQ_TAG_EN
        input  cmd_tag,
        output res_tag,
`endif
        output cmd_ready, res_valid, res_p, res_carryout,
        input  res_ready
    );

endinterface

// File: rtl/dsp_seq_fifo.sv
// dsp_seq_fifo: synchronous result FIFO with occupancy count. The caller
// guarantees no push when full; pops while empty are ignored.
module dsp_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 49
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign rdata  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is only read after it has been written.
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dsp_cmd_sequencer.sv
// dsp_cmd_sequencer: issues commands into one dsp slice, tracks them through
// the DSP_LAT-cycle slice pipeline and returns P/CARRYOUT in order.
// Optional feature macro: DSP_SEQ_TAG_EN (tag travels with each operation).
module dsp_cmd_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int DSP_LAT = 4,
    parameter int DEPTH   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    dsp_seq_if.slave            bus,
    output logic [AB_W-1:0]     DSP_A,
    output logic [AB_W-1:0]     DSP_B,
    output logic [AB_W-1:0]     DSP_D,
    output logic [C_W-1:0]      DSP_C,
    output logic [OPMODE_W-1:0] DSP_OPMODE,
    output logic                DSP_CARRYIN,
    output logic                DSP_CE,
    output logic                DSP_RST,
    input  logic [P_W-1:0]      DSP_P,
    input  logic                DSP_CARRYOUT
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    dsp_cmd_t         cmd_in;
    dsp_cmd_t         dsp_q;
    dsp_res_t         push_d;
    dsp_res_t         head;
    logic [DSP_LAT:0] vld_sr;
    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             accept;
    logic             exit_vld;
    logic             pop;

    assign cmd_in = '{opmode:  bus.cmd_opmode,
                      a:       bus.cmd_a,
                      b:       bus.cmd_b,
                      d:       bus.cmd_d,
                      c:       bus.cmd_c,
                      carryin: bus.cmd_carryin};

    // Credit from registered counts only, so a pop frees its slot next cycle.
    assign bus.cmd_ready = !RST &&
        (({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(DEPTH));
    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign exit_vld = vld_sr[DSP_LAT];
    assign pop      = bus.res_valid && bus.res_ready;

    // Slice drive registers: the accepted command for one cycle, NOP otherwise.
    always_ff @(posedge CLK) begin
        if (RST)         dsp_q <= DSP_CMD_NOP;
        else if (accept) dsp_q <= cmd_in;
        else             dsp_q <= DSP_CMD_NOP;
    end

    // In-flight tracker: one valid bit per pipeline cycle plus a running count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_sr       <= '0;
            inflight_cnt <= '0;
        end else begin
            vld_sr       <= {vld_sr[DSP_LAT-1:0], accept};
            inflight_cnt <= inflight_cnt + CNT_W'(accept) - CNT_W'(exit_vld);
        end
    end

`ifdef DSP_SEQ_TAG_EN
    logic [TAG_W-1:0] tag_sr [DSP_LAT+1];

    // Tag pipeline alongside the valid bits; only read where its bit is set.
    always_ff @(posedge CLK) begin
        tag_sr[0] <= bus.cmd_tag;
        for (int i = 1; i <= DSP_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
`endif

    // Result payload: slice outputs in the cycle the op leaves the tracker.
    always_comb begin
        // NOTE: assign a full default first so no field is left to infer a latch.
        push_d          = '0;
        push_d.p        = DSP_P;
        push_d.carryout = DSP_CARRYOUT;
`ifdef DSP_SEQ_TAG_EN
        push_d.tag      = tag_sr[DSP_LAT];
`endif
    end

    dsp_seq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(dsp_res_t))
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (exit_vld),
        .wdata (push_d),
        .pop   (pop),
        .rdata (head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign bus.res_valid    = !RST && !fifo_empty;
    assign bus.res_p        = head.p;
    assign bus.res_carryout = head.carryout;
`ifdef DSP_SEQ_TAG_EN
    assign bus.res_tag      = head.tag;
`endif

    assign DSP_A       = dsp_q.a;
    assign DSP_B       = dsp_q.b;
    assign DSP_D       = dsp_q.d;
    assign DSP_C       = dsp_q.c;
    assign DSP_OPMODE  = dsp_q.opmode;
    assign DSP_CARRYIN = dsp_q.carryin;
    assign DSP_CE      = 1'b1;
    assign DSP_RST     = RST;

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// Testbench for dsp_cmd_sequencer: a behavioural dsp slice model (3 input
// stages + P register, 4-cycle latency) drives DSP_P; the reference model
// chains each accepted command's result through the previous P value.
// Build with DSP_SEQ_TAG_EN defined to exercise tag echo.
module tb_dsp_cmd_sequencer;
    import dsp_seq_pkg::*;

    typedef struct packed {
        logic [7:0]       op;
        logic [17:0]      a;
        logic [17:0]      b;
        logic [17:0]      d;
        logic [47:0]      c;
        logic             ci;
        logic [TAG_W-1:0] tag;
    } tb_cmd_t;

    typedef struct packed {
        logic [47:0]      p;
        logic             co;
        logic [TAG_W-1:0] tag;
    } tb_res_t;

    localparam tb_cmd_t TB_NOP = '{op: 8'h08, default: '0};
    localparam logic [7:0] OPS [12] = '{8'h01, 8'h09, 8'h0D, 8'h0C, 8'h0F, 8'h11,
                                        8'h19, 8'h1D, 8'h51, 8'h0A, 8'h0E, 8'h08};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_seq_if bus ();

    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c, dsp_p;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce, dsp_rst, dsp_carryout;

    dsp_cmd_sequencer #(.DSP_LAT(4), .DEPTH(8)) dut (
        .CLK          (clk),
        .RST          (rst),
        .bus          (bus),
        .DSP_A        (dsp_a),
        .DSP_B        (dsp_b),
        .DSP_D        (dsp_d),
        .DSP_C        (dsp_c),
        .DSP_OPMODE   (dsp_opmode),
        .DSP_CARRYIN  (dsp_carryin),
        .DSP_CE       (dsp_ce),
        .DSP_RST      (dsp_rst),
        .DSP_P        (dsp_p),
        .DSP_CARRYOUT (dsp_carryout)
    );

    int        checks   = 0;
    int        failures = 0;
    int        cyc      = 0;
    tb_res_t   exp_q [$];
    logic [47:0] acc    = '0;
    bit        rr_mode  = 1'b0;
    bit        rr_fixed = 1'b1;
    bit        stall_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Slice arithmetic: signed 18x18 multiply with optional D+/-B pre-add,
    // X mux {0, M, P, D:A:B}, Z mux {0, 0, P, C}, post-add with carry.
    function automatic logic [48:0] calc(input tb_cmd_t c, input logic [47:0] p);
        logic [17:0]        bp;
        logic signed [35:0] prod;
        logic [47:0]        x, z;
        bp   = c.op[4] ? (c.op[6] ? c.d - c.b : c.d + c.b) : c.b;
        prod = $signed(c.a) * $signed(bp);
        case (c.op[1:0])
            2'd0:    x = '0;
            2'd1:    x = {{12{prod[35]}}, prod};
            2'd2:    x = p;
            default: x = {c.d[11:0], c.a, c.b};
        endcase
        case (c.op[3:2])
            2'd2:    z = p;
            2'd3:    z = c.c;
            default: z = '0;
        endcase
        return {1'b0, z} + {1'b0, x} + 49'(c.ci);
    endfunction

    // Slice model.
    tb_cmd_t     st [3];
    logic [47:0] sp;
    logic        sco;
    logic [48:0] slice_sum;
    assign dsp_p        = sp;
    assign dsp_carryout = sco;

    always @(posedge clk) begin
        if (dsp_rst) begin
            st[0] <= TB_NOP;
            st[1] <= TB_NOP;
            st[2] <= TB_NOP;
            sp    <= '0;
            sco   <= 1'b0;
        end else if (dsp_ce) begin
            slice_sum = calc(st[2], sp);
            sp    <= slice_sum[47:0];
            sco   <= slice_sum[48];
            st[2] <= st[1];
            st[1] <= st[0];
            st[0] <= '{op: dsp_opmode, a: dsp_a, b: dsp_b, d: dsp_d,
                       c: dsp_c, ci: dsp_carryin, tag: '0};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        bus.res_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_fixed;

    // Monitor: every valid cycle must show the queue head; pop on handshake.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (stall_prev) check("res_hold_valid", 64'(bus.res_valid), 64'd1);
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_res_valid", 64'(bus.res_valid), 64'd0);
                end else begin
                    check("res_p", 64'(bus.res_p), 64'(exp_q[0].p));
                    check("res_carryout", 64'(bus.res_carryout), 64'(exp_q[0].co));
`ifdef DSP_SEQ_TAG_EN
                    check("res_tag", 64'(bus.res_tag), 64'(exp_q[0].tag));
`endif
                    if (bus.res_ready) void'(exp_q.pop_front());
                end
            end
            stall_prev = bus.res_valid && !bus.res_ready;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic tb_cmd_t mk_cmd(input logic [7:0] op, input logic [17:0] a,
                                       input logic [17:0] b, input logic [17:0] d,
                                       input logic [TAG_W-1:0] tag);
        tb_cmd_t c;
        c     = '0;
        c.op  = op;
        c.a   = a;
        c.b   = b;
        c.d   = d;
        c.tag = tag;
        return c;
    endfunction

    function automatic tb_cmd_t rand_cmd();
        tb_cmd_t c;
        c.op  = OPS[$urandom_range(0, 11)];
        c.a   = 18'($urandom);
        c.b   = 18'($urandom);
        c.d   = 18'($urandom);
        c.c   = {16'($urandom), 32'($urandom)};
        c.ci  = 1'($urandom);
        c.tag = TAG_W'($urandom);
        return c;
    endfunction

    task automatic model_push(input tb_cmd_t c);
        logic [48:0] r;
        tb_res_t     e;
        r     = calc(c, acc);
        acc   = r[47:0];
        e.p   = r[47:0];
        e.co  = r[48];
        e.tag = c.tag;
        exp_q.push_back(e);
    endtask

    task automatic drive_cmd(input tb_cmd_t c);
        bus.cmd_opmode  = c.op;
        bus.cmd_a       = c.a;
        bus.cmd_b       = c.b;
        bus.cmd_d       = c.d;
        bus.cmd_c       = c.c;
        bus.cmd_carryin = c.ci;
`ifdef DSP_SEQ_TAG_EN
        bus.cmd_tag     = c.tag;
`endif
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input tb_cmd_t c);
        int n = 0;
        drive_cmd(c);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            model_push(c);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        acc = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_res_valid(output bit seen);
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = bus.res_valid;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_cyc;
        int  run;
        int  i;
        bit  seen;

        bus.cmd_valid = 1'b0;
        drive_cmd('0);

        // Reset held two cycles.
        @(negedge clk);
        @(negedge clk);
        check("rst_dsp_rst",    64'(dsp_rst),        64'd1);
        check("rst_res_valid",  64'(bus.res_valid),  64'd0);
        check("rst_cmd_ready",  64'(bus.cmd_ready),  64'd0);
        check("rst_opmode",     64'(dsp_opmode),     64'h08);
        check("rst_dsp_a",      64'(dsp_a),          64'd0);
        check("rst_dsp_ce",     64'(dsp_ce),         64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_cmd_ready", 64'(bus.cmd_ready),  64'd1);
        check("post_dsp_rst",   64'(dsp_rst),        64'd0);

        // Single multiply with latency measurement.
        send(mk_cmd(8'h01, 18'd5, 18'd3, 18'd0, 4'd0));
        acc_cyc = cyc;
        wait_res_valid(seen);
        check("mult_res_seen", 64'(seen), 64'd1);
        check("res_latency", 64'(cyc - acc_cyc), 64'd5);
        drain();

        // Back-to-back accumulate, then one after an idle gap.
        do_reset(2);
        @(negedge clk);
        for (int k = 0; k < 3; k++) send(mk_cmd(8'h09, 18'd2, 18'd3, 18'd0, 4'd0));
        wait_res_valid(seen);
        run = 0;
        repeat (3) begin
            if (bus.res_valid) run++;
            @(negedge clk);
        end
        check("b2b_result_run", 64'(run), 64'd3);
        repeat (4) @(negedge clk);
        send(mk_cmd(8'h09, 18'd2, 18'd3, 18'd0, 4'd0));
        drain();

        // Pre-adder multiply.
        send(mk_cmd(8'h11, 18'd4, 18'd3, 18'd7, 4'd0));
        drain();

        // Credit limit with a stalled consumer.
        rr_fixed = 1'b0;
        repeat (2) @(negedge clk);
        i = 0;
        for (int t = 0; t < 30; t++) begin
            if (i < 12) begin
                drive_cmd(mk_cmd(8'h01, 18'(i), 18'd1, 18'd0, 4'd0));
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    model_push(mk_cmd(8'h01, 18'(i), 18'd1, 18'd0, 4'd0));
                    i++;
                end
            end
            @(negedge clk);
        end
        check("credit_accepted", 64'(i), 64'd8);
        check("credit_ready_low", 64'(bus.cmd_ready), 64'd0);
        rr_fixed = 1'b1;
        for (int t = 0; t < 200 && i < 12; t++) begin
            drive_cmd(mk_cmd(8'h01, 18'(i), 18'd1, 18'd0, 4'd0));
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready) begin
                model_push(mk_cmd(8'h01, 18'(i), 18'd1, 18'd0, 4'd0));
                i++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("credit_all_accepted", 64'(i), 64'd12);
        drain();

        // Reset while operations are in flight.
        for (int k = 0; k < 3; k++) send(mk_cmd(8'h01, 18'(10 + k), 18'd1, 18'd0, 4'd0));
        @(negedge clk);
        do_reset(2);
        check("flush_res_valid", 64'(bus.res_valid), 64'd0);
        repeat (12) @(negedge clk);
        check("flush_still_idle", 64'(bus.res_valid), 64'd0);
        send(mk_cmd(8'h01, 18'd2, 18'd2, 18'd0, 4'd0));
        drain();

`ifdef DSP_SEQ_TAG_EN
        // Tag echo on back-to-back commands.
        send(mk_cmd(8'h01, 18'd1, 18'd7, 18'd0, 4'd3));
        send(mk_cmd(8'h09, 18'd2, 18'd5, 18'd0, 4'd9));
        send(mk_cmd(8'h01, 18'd3, 18'd4, 18'd0, 4'd5));
        drain();
`endif

        // Randomized traffic with random back-pressure and one mid-run reset.
        rr_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (k == 150) begin
                do_reset(2);
                @(negedge clk);
            end
            send(rand_cmd());
        end
        rr_mode = 1'b0;
        rr_fixed = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
